// File: rtl/cnn_pool_stream.sv
// Streaming 2x2 stride-2 max-pool with optional ReLU, fed in raster order by the conv core.
// A half-row line buffer keeps the top-row partial maxima until the matching bottom row arrives.
module cnn_pool_stream #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned M_p    = 1,
  parameter int unsigned R_p    = 4,
  parameter int unsigned C_p    = 4,
  parameter int unsigned RELU_p = 1,
  localparam int unsigned MapW  = $clog2(M_p) + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic [MapW-1:0]   map_o,
  input  logic              ready_i
);

  localparam int unsigned ColW   = (C_p > 1) ? $clog2(C_p) : 1;
  localparam int unsigned RowW   = (R_p > 1) ? $clog2(R_p) : 1;
  localparam int unsigned LbN    = C_p / 2;
  localparam int unsigned LbIdxW = (LbN > 1) ? $clog2(LbN) : 1;

  localparam logic [ColW-1:0] ColMax = ColW'(C_p - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(R_p - 1);
  localparam logic [MapW-1:0] MapMax = MapW'(M_p - 1);

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [MapW-1:0] map_q, map_d;
  logic [MapW-1:0] map_out_q, map_out_d;
  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic last_q, last_d;

  logic signed [DATA_W-1:0] lbuf_q [LbN];
  logic [LbIdxW-1:0]        lb_idx;
  logic                     lb_we;

  logic                     accept;
  logic                     fire;
  logic                     win_last;
  logic signed [DATA_W-1:0] data_s;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] pool_raw;
  logic signed [DATA_W-1:0] pool;

  // Backpressure stalls the whole stream, regardless of window position.
  assign ready_o  = ~valid_q | ready_i;
  assign accept   = valid_i & ready_o;
  assign fire     = accept & col_q[0] & row_q[0];
  assign lb_we    = accept & col_q[0] & ~row_q[0];
  assign lb_idx   = LbIdxW'(col_q >> 1);
  assign win_last = (row_q == RowMax) && (col_q == ColMax);

  assign data_s   = data_i;
  assign pair_max = smax(hold_q, data_s);
  assign pool_raw = smax(pair_max, lbuf_q[lb_idx]);
  assign pool     = ((RELU_p != 0) && pool_raw[DATA_W-1]) ? '0 : pool_raw;

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    map_d     = map_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    map_out_d = map_out_q;

    if (accept) begin
      if (col_q == ColMax) begin
        col_d = '0;
        if (row_q == RowMax) begin
          row_d = '0;
          map_d = (map_q == MapMax) ? '0 : map_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) hold_d = data_s;
    end

    // A new window result replaces a consumed one in the same cycle.
    if (fire) begin
      valid_d   = 1'b1;
      data_d    = pool;
      last_d    = win_last;
      map_out_d = map_q;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_q     <= '0;
      row_q     <= '0;
      map_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      map_out_q <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      map_q     <= map_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      map_out_q <= map_out_d;
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge clk_i) begin
    if (lb_we) lbuf_q[lb_idx] <= pair_max;
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign map_o   = map_out_q;

endmodule

// File: tb/tb_cnn_pool_stream.sv
// Directed and randomized checks of the streaming max-pool stage against hand-computed results.
module tb_cnn_pool_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [15:0] data_i  = '0;

  logic        d_ready, d_valid, d_last;
  logic [15:0] d_data;
  logic [1:0]  d_map;
  logic        r_ready, r_valid, r_last;
  logic [15:0] r_data;
  logic [0:0]  r_map;

  logic        b_valid_i = 1'b0;
  logic        b_ready_i = 1'b0;
  logic [15:0] b_data_i  = '0;
  logic        b_ready, b_valid, b_last;
  logic [15:0] b_data;
  logic [0:0]  b_map;

  cnn_pool_stream #(.DATA_W(16), .M_p(2), .R_p(4), .C_p(4), .RELU_p(0)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i), .ready_o(d_ready),
    .valid_o(d_valid), .data_o(d_data), .last_o(d_last), .map_o(d_map), .ready_i(ready_i)
  );

  cnn_pool_stream #(.DATA_W(16), .M_p(1), .R_p(4), .C_p(4), .RELU_p(1)) u_relu (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i), .ready_o(r_ready),
    .valid_o(r_valid), .data_o(r_data), .last_o(r_last), .map_o(r_map), .ready_i(ready_i)
  );

  cnn_pool_stream #(.DATA_W(16), .M_p(1), .R_p(8), .C_p(8), .RELU_p(0)) u_big (
    .clk_i(clk), .reset_i(reset_i), .valid_i(b_valid_i), .data_i(b_data_i), .ready_o(b_ready),
    .valid_o(b_valid), .data_o(b_data), .last_o(b_last), .map_o(b_map), .ready_i(b_ready_i)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [15:0] dq [$];
  logic        dl [$];
  logic [1:0]  dm [$];
  int          dc [$];
  logic [15:0] rq [$];
  logic [15:0] bq [$];
  logic        bl [$];
  int          acc_c [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed output handshake; the transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (d_valid && ready_i) begin
        dq.push_back(d_data);
        dl.push_back(d_last);
        dm.push_back(d_map);
        dc.push_back(cyc);
      end
      if (r_valid && ready_i) rq.push_back(r_data);
      if (b_valid && b_ready_i) begin
        bq.push_back(b_data);
        bl.push_back(b_last);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset_i   = 1'b1;
    valid_i   = 1'b0;
    b_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_i = 1'b0;
    dq.delete(); dl.delete(); dm.delete(); dc.delete();
    rq.delete(); bq.delete(); bl.delete(); acc_c.delete();
  endtask

  task automatic send_pixel(input logic [15:0] v);
    bit ok = 1'b0;
    valid_i = 1'b1;
    data_i  = v;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (d_ready) begin
        ok = 1'b1;
        acc_c.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: pixel %0d not accepted, required acceptance within 100 cycles",
               $signed(v));
    end
  endtask

  task automatic send_ramp(input int base, input int n);
    for (int i = 0; i < n; i++) send_pixel(16'(base + i));
  endtask

  task automatic wait_out(input int n);
    for (int t = 0; t < 200 && dq.size() < n; t++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (dq.size() != n) begin
      n_fail++;
      $display("FAIL out_count: got %0d outputs, required %0d", dq.size(), n);
    end
  endtask

  task automatic test_reset();
    ready_i = 1'b0;
    do_reset();
    @(negedge clk);
    n_checks += 5;
    if (d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", d_valid); end
    if (d_data !== 16'd0) begin n_fail++; $display("FAIL rst_data: got %0h required 0", d_data); end
    if (d_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b required 0", d_last); end
    if (d_map !== 2'd0) begin n_fail++; $display("FAIL rst_map: got %0d required 0", d_map); end
    if (d_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", d_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_ramp();
    logic [15:0] exp_d [4];
    int          pix [4];
    exp_d = '{16'd5, 16'd7, 16'd13, 16'd15};
    pix   = '{5, 7, 13, 15};
    do_reset();
    ready_i = 1'b1;
    send_ramp(0, 16);
    wait_out(4);
    for (int k = 0; k < 4 && k < dq.size() && acc_c.size() == 16; k++) begin
      n_checks += 4;
      if (dq[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL ramp_data[%0d]: got %0d required %0d", k, dq[k], exp_d[k]);
      end
      if (dl[k] !== (k == 3)) begin
        n_fail++; $display("FAIL ramp_last[%0d]: got %b required %b", k, dl[k], k == 3);
      end
      if (dm[k] !== 2'd0) begin
        n_fail++; $display("FAIL ramp_map[%0d]: got %0d required 0", k, dm[k]);
      end
      if (dc[k] != acc_c[pix[k]] + 1) begin
        n_fail++;
        $display("FAIL ramp_latency[%0d]: out cycle %0d required %0d", k, dc[k], acc_c[pix[k]] + 1);
      end
    end
  endtask

  task automatic test_relu();
    logic [15:0] exp_d [4];
    exp_d = '{16'hFFFF, 16'hFFFD, 16'hFFF7, 16'hFFF5};
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) send_pixel(16'(-(i + 1)));
    wait_out(4);
    n_checks++;
    if (rq.size() != 4) begin
      n_fail++; $display("FAIL relu_count: got %0d required 4", rq.size());
    end
    for (int k = 0; k < 4 && k < dq.size() && k < rq.size(); k++) begin
      n_checks += 2;
      if (dq[k] !== exp_d[k]) begin
        n_fail++;
        $display("FAIL norelu_data[%0d]: got %0d required %0d", k, $signed(dq[k]), $signed(exp_d[k]));
      end
      if (rq[k] !== 16'd0) begin
        n_fail++; $display("FAIL relu_data[%0d]: got %0d required 0", k, $signed(rq[k]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_d [4];
    exp_d = '{16'd5, 16'd7, 16'd13, 16'd15};
    do_reset();
    ready_i = 1'b1;
    fork
      send_ramp(0, 16);
      begin
        bit seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(posedge clk); #1;
          seen = d_valid;
        end
        ready_i = 1'b0;
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL bp_first_valid: got 0 required 1"); end
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_checks += 3;
          if (d_data !== 16'd5) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got %0d required 5", s, d_data);
          end
          if (d_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready[%0d]: got %b required 0", s, d_ready);
          end
          if (d_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_valid[%0d]: got %b required 1", s, d_valid);
          end
          @(posedge clk); #1;
        end
        ready_i = 1'b1;
      end
    join
    wait_out(4);
    for (int k = 0; k < 4 && k < dq.size(); k++) begin
      n_checks++;
      if (dq[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL bp_data[%0d]: got %0d required %0d", k, dq[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_multimap();
    logic [15:0] exp_d [8];
    exp_d = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd105, 16'd107, 16'd113, 16'd115};
    do_reset();
    ready_i = 1'b1;
    send_ramp(0, 16);
    send_ramp(100, 16);
    wait_out(8);
    for (int k = 0; k < 8 && k < dq.size(); k++) begin
      n_checks += 3;
      if (dq[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL mm_data[%0d]: got %0d required %0d", k, dq[k], exp_d[k]);
      end
      if (dm[k] !== 2'(k / 4)) begin
        n_fail++; $display("FAIL mm_map[%0d]: got %0d required %0d", k, dm[k], k / 4);
      end
      if (dl[k] !== (k == 3 || k == 7)) begin
        n_fail++; $display("FAIL mm_last[%0d]: got %b required %b", k, dl[k], k == 3 || k == 7);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp_d [4];
    exp_d = '{16'd5, 16'd7, 16'd13, 16'd15};
    do_reset();
    ready_i = 1'b0;
    send_ramp(0, 6);
    @(negedge clk);
    n_checks++;
    if (d_valid !== 1'b1) begin n_fail++; $display("FAIL abort_pending: got %b required 1", d_valid); end
    do_reset();
    @(negedge clk);
    n_checks++;
    if (d_valid !== 1'b0) begin n_fail++; $display("FAIL abort_cleared: got %b required 0", d_valid); end
    @(posedge clk); #1;
    ready_i = 1'b1;
    send_ramp(0, 16);
    wait_out(4);
    for (int k = 0; k < 4 && k < dq.size(); k++) begin
      n_checks += 2;
      if (dq[k] !== exp_d[k]) begin
        n_fail++; $display("FAIL abort_data[%0d]: got %0d required %0d", k, dq[k], exp_d[k]);
      end
      if (dm[k] !== 2'd0) begin
        n_fail++; $display("FAIL abort_map[%0d]: got %0d required 0", k, dm[k]);
      end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] img [128];
    logic signed [15:0] exp_d [32];
    logic               exp_l [32];
    logic signed [15:0] m;
    int                 idx = 0;
    for (int i = 0; i < 128; i++) img[i] = 16'($urandom);
    for (int f = 0; f < 2; f++) begin
      for (int pr = 0; pr < 4; pr++) begin
        for (int pc = 0; pc < 4; pc++) begin
          int b = f * 64 + pr * 16 + pc * 2;
          m = img[b];
          if (img[b + 1] > m) m = img[b + 1];
          if (img[b + 8] > m) m = img[b + 8];
          if (img[b + 9] > m) m = img[b + 9];
          exp_d[f * 16 + pr * 4 + pc] = m;
          exp_l[f * 16 + pr * 4 + pc] = (pr == 3 && pc == 3);
        end
      end
    end
    do_reset();
    for (int t = 0; t < 3000 && idx < 128; t++) begin
      b_valid_i = ($urandom_range(0, 3) != 0);
      b_data_i  = img[idx];
      b_ready_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (b_valid_i && b_ready) idx++;
      @(posedge clk); #1;
    end
    b_valid_i = 1'b0;
    b_ready_i = 1'b1;
    for (int t = 0; t < 100 && bq.size() < 32; t++) begin
      @(posedge clk); #1;
    end
    n_checks += 2;
    if (idx != 128) begin n_fail++; $display("FAIL rand_sent: got %0d required 128", idx); end
    if (bq.size() != 32) begin n_fail++; $display("FAIL rand_count: got %0d required 32", bq.size()); end
    for (int k = 0; k < 32 && k < bq.size(); k++) begin
      n_checks += 2;
      if (bq[k] !== exp_d[k]) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got %0d required %0d", k, $signed(bq[k]), exp_d[k]);
      end
      if (bl[k] !== exp_l[k]) begin
        n_fail++; $display("FAIL rand_last[%0d]: got %b required %b", k, bl[k], exp_l[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_relu();
    test_backpressure();
    test_multimap();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion before 400000");
    $fatal(1);
  end

endmodule
